// File: rtl/hififo_rc_reorder_if.sv
// Bus bundle for hififo_rc_reorder: tag allocation, completion input, in-order output and status.
interface hififo_rc_reorder_if #(
    parameter int unsigned TAG_BITS = 5
);
    logic                rr_tag_valid;
    logic                rr_tag_ready;
    logic [7:0]          rr_tag;
    logic                rc_valid;
    logic [7:0]          rc_tag;
    logic [5:0]          rc_index;
    logic [63:0]         rc_data;
    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_data;
    logic [TAG_BITS:0]   outstanding;
    logic                error;

    // DMA engine / downstream side
    modport master (
        output rr_tag_ready, rc_valid, rc_tag, rc_index, rc_data, out_ready,
        input  rr_tag_valid, rr_tag, out_valid, out_data, outstanding, error
    );

    // Reorder buffer side
    modport slave (
        input  rr_tag_ready, rc_valid, rc_tag, rc_index, rc_data, out_ready,
        output rr_tag_valid, rr_tag, out_valid, out_data, outstanding, error
    );
endinterface

// File: rtl/hififo_rc_reorder.sv
// Read-completion reorder buffer: issues tags in circular order, absorbs out-of-order completions,
// streams each tag's block out in issue order. Define HIFIFO_RC_PROTECT_EN to drop and flag bad completions.
module hififo_rc_reorder #(
    parameter int unsigned TAG_BITS = 5,
    parameter int unsigned QW_BITS  = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    hififo_rc_reorder_if.slave bus
);
    localparam int unsigned NTAGS = 1 << TAG_BITS;
    localparam int unsigned NQW   = 1 << QW_BITS;
    localparam int unsigned OW    = TAG_BITS + 1;
    localparam int unsigned CW    = QW_BITS + 1;

    typedef enum logic [1:0] {IDLE, READ, WAIT} state_e;

    logic [63:0]         mem_q [NTAGS*NQW];

    state_e              state_q, state_d;
    logic [TAG_BITS-1:0] alloc_ptr_q, alloc_ptr_d, head_ptr_q, head_ptr_d;
    logic [QW_BITS-1:0]  rd_idx_q, rd_idx_d, out_idx_q, out_idx_d;
    logic [CW-1:0]       cnt_q [NTAGS];
    logic [CW-1:0]       cnt_d [NTAGS];
    logic [NTAGS-1:0]    done_q, done_d;
    logic [OW-1:0]       outstanding_q, outstanding_d;
    logic                rr_tag_valid_q, rr_tag_valid_d;
    logic [63:0]         out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic                out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    logic [TAG_BITS-1:0] rc_tag;
    logic [QW_BITS-1:0]  rc_idx;
    logic [63:0]         rd_data;
    logic                alloc, pop, issue, last_out, wr_en;
    logic                unused_rc_hi;

    assign rc_tag       = bus.rc_tag[TAG_BITS-1:0];
    assign rc_idx       = bus.rc_index[QW_BITS-1:0];
    assign unused_rc_hi = ^{bus.rc_tag[7:TAG_BITS], bus.rc_index[5:QW_BITS]};
    assign alloc        = rr_tag_valid_q && bus.rr_tag_ready;
    assign pop          = out_valid_q && bus.out_ready;
    assign last_out     = pop && (out_idx_q == QW_BITS'(NQW - 1));
    assign rd_data      = mem_q[{head_ptr_q, rd_idx_q}];

`ifdef HIFIFO_RC_PROTECT_EN
    // A tag is live from allocation until the drain has read its last qword.
    logic [OW-1:0]       inflight_q, inflight_d;
    logic                error_q, error_d, rc_bad;
    logic [TAG_BITS-1:0] rc_off;

    assign rc_off    = rc_tag - head_ptr_q;
    assign rc_bad    = (OW'(rc_off) >= inflight_q) || done_q[rc_tag];
    assign wr_en     = bus.rc_valid && !rc_bad;
    assign bus.error = error_q;
`else
    assign wr_en     = bus.rc_valid;
    assign bus.error = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        alloc_ptr_d    = alloc_ptr_q;
        head_ptr_d     = head_ptr_q;
        rd_idx_d       = rd_idx_q;
        cnt_d          = cnt_q;
        done_d         = done_q;
        out_data_d     = out_data_q;
        skid_data_d    = skid_data_q;
        out_valid_d    = out_valid_q;
        skid_valid_d   = skid_valid_q;
        issue          = 1'b0;
        out_idx_d      = out_idx_q + QW_BITS'(pop);
        outstanding_d  = outstanding_q + OW'(alloc) - OW'(last_out);
        rr_tag_valid_d = (outstanding_d != OW'(NTAGS));
`ifdef HIFIFO_RC_PROTECT_EN
        inflight_d     = inflight_q + OW'(alloc);
        error_d        = error_q || (bus.rc_valid && rc_bad);
`endif

        if (alloc) begin
            alloc_ptr_d         = alloc_ptr_q + 1'b1;
            cnt_d[alloc_ptr_q]  = '0;
            done_d[alloc_ptr_q] = 1'b0;
        end

        if (wr_en) begin
            cnt_d[rc_tag] = cnt_d[rc_tag] + CW'(1);
            if (cnt_d[rc_tag] == CW'(NQW)) done_d[rc_tag] = 1'b1;
        end

        // Drain: one RAM read per cycle whenever the skid pair has room after this cycle's pop.
        case (state_q)
            IDLE: if (done_q[head_ptr_q]) state_d = READ;
            READ, WAIT: begin
                issue = !skid_valid_q || pop;
                if (issue) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    state_d  = READ;
                    if (rd_idx_q == QW_BITS'(NQW - 1)) begin
                        done_d[head_ptr_q] = 1'b0;
                        head_ptr_d         = head_ptr_q + 1'b1;
                        state_d            = done_q[head_ptr_d] ? READ : IDLE;
`ifdef HIFIFO_RC_PROTECT_EN
                        inflight_d         = inflight_d - OW'(1);
`endif
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register plus one skid slot; the skid slot only fills while the output is stalled.
        if (pop) begin
            if (skid_valid_q) begin
                out_data_d = skid_data_q;
                if (issue) skid_data_d  = rd_data;
                else       skid_valid_d = 1'b0;
            end else if (issue) begin
                out_data_d = rd_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (issue) begin
            if (!out_valid_q) begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = rd_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            alloc_ptr_q    <= '0;
            head_ptr_q     <= '0;
            rd_idx_q       <= '0;
            out_idx_q      <= '0;
            cnt_q          <= '{default: '0};
            done_q         <= '0;
            outstanding_q  <= '0;
            rr_tag_valid_q <= 1'b1;
            out_data_q     <= '0;
            skid_data_q    <= '0;
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
`ifdef HIFIFO_RC_PROTECT_EN
            inflight_q     <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            alloc_ptr_q    <= alloc_ptr_d;
            head_ptr_q     <= head_ptr_d;
            rd_idx_q       <= rd_idx_d;
            out_idx_q      <= out_idx_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            outstanding_q  <= outstanding_d;
            rr_tag_valid_q <= rr_tag_valid_d;
            out_data_q     <= out_data_d;
            skid_data_q    <= skid_data_d;
            out_valid_q    <= out_valid_d;
            skid_valid_q   <= skid_valid_d;
`ifdef HIFIFO_RC_PROTECT_EN
            inflight_q     <= inflight_d;
            error_q        <= error_d;
`endif
        end
    end

    // Completion write port; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[{rc_tag, rc_idx}] <= bus.rc_data;
    end

    assign bus.rr_tag_valid = rr_tag_valid_q;
    assign bus.rr_tag       = 8'(alloc_ptr_q);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.outstanding  = outstanding_q;
endmodule

// File: doc/hififo_rc_reorder.md
# hififo_rc_reorder

Read-completion reorder buffer for the from-PC (FPC) DMA path. It sits directly downstream of the PCIe RX parser and upstream of the FPC user FIFO. It hands out read-request tags in strict circular order and absorbs completion qwords that arrive out of order across tags. It then streams each tag's data block out in tag-issue order through a valid/ready interface.

## Interface
Parameters:
- TAG_BITS, 5, log2 of tags in flight (32 tags)
- QW_BITS, 4, log2 of qwords per read request (16 qwords = 128 bytes)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- rr_tag_valid  out  1  a free tag is available for a new read request
- rr_tag_ready  in  1  read request issued with rr_tag; consumes the tag
- rr_tag  out  8  tag to issue; upper 8-TAG_BITS bits zero
- rc_valid  in  1  completion qword valid
- rc_tag  in  8  completion tag; low TAG_BITS bits used
- rc_index  in  6  qword index within the request; low QW_BITS bits used
- rc_data  in  64  completion qword
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  64  in-order data
- outstanding  out  TAG_BITS+1  tags allocated and not yet fully drained
- error  out  1  sticky protocol error (HIFIFO_RC_PROTECT_EN only)

## Operation
- Storage: 2^(TAG_BITS+QW_BITS) x 64 synchronous RAM, addressed {tag, index}. There is one write port (completions) and one read port (drain).
- Pointers: alloc_ptr and head_ptr, each TAG_BITS wide, wrapping modulo 2^TAG_BITS. There is also a per-tag qword counter of QW_BITS+1 bits and a per-tag done flag.
- Allocation:
  - rr_tag = alloc_ptr and rr_tag_valid = (outstanding != 2^TAG_BITS).
  - The tag is consumed when rr_tag_valid && rr_tag_ready. This increments alloc_ptr and clears that tag's counter and done flag.
- Completion:
  - On rc_valid, write rc_data to RAM[{rc_tag, rc_index}] and increment that tag's counter.
  - When the counter reaches 2^QW_BITS, set the done flag.
- Drain state machine, with states IDLE, READ and WAIT:
  - IDLE: moves to READ when done[head_ptr] is set.
  - READ: issues RAM reads for indexes 0..2^QW_BITS-1 into a 2-entry output skid buffer. It stalls while the buffer is full.
  - After the last index is read, clear done[head_ptr] and increment head_ptr. Then return to IDLE, or stay in READ if the next head tag is already done.
  - WAIT is entered from READ when the buffer is full, and exited when a slot frees.
- outstanding:
  - Increments on allocation.
  - Decrements when the last qword of a tag is transferred out.
  - Is unchanged when both happen in the same cycle.
- Reset (asynchronous, at any time, including mid-transfer):
  - Pointers, counters, done flags, skid buffer, outstanding and error all go to 0, and the FSM goes to IDLE.
  - RAM contents are don't-care.
  - In-flight completions are discarded.

## Timing
- Reset values: rr_tag_valid=1, rr_tag=0, out_valid=0, out_data=0, outstanding=0, error=0.
- Completion write to done flag: 1 cycle. The final qword's rc_valid at cycle N sets done at N+1.
- Done flag to first out_valid: 2 cycles (FSM decision plus RAM read). Under continuous out_ready, the final qword at N gives out_valid at N+3.
- Throughput: 1 qword/cycle sustained, including back-to-back tags with no bubble.
- Handshake:
  - A transfer occurs on out_valid && out_ready.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- rr_tag_ready sampled while rr_tag_valid=0 is ignored.
- A simultaneous completion write and drain read to different addresses are both serviced in the same cycle.

## Configuration
- HIFIFO_RC_PROTECT_EN defined:
  - error is set and held until reset on any of: an rc_valid whose tag is not allocated (tag not in [head_ptr, alloc_ptr) modulo wrap), or an rc_valid to a tag whose done flag is already set.
  - The offending qword is dropped and its counter is not incremented.
- Not defined:
  - error is tied to 0 and no checking logic is built.
  - Such completions are written and counted unconditionally.

## Test plan
- Reset then allocate 3 tags with rr_tag_ready held high -> rr_tag 0,1,2; outstanding=3.
- Completions for tag 1 (16 qwords, data 0x100+i), then tag 0 (0x000+i) -> out_data 0x000..0x00F followed by 0x100..0x10F, with no out_valid before all of tag 0 is written.
- Allocate 32 tags without completing any -> rr_tag_valid=0 and outstanding=32. Drain tag 0 -> rr_tag_valid=1 the cycle after its last transfer, and rr_tag wraps to 0.
- Toggle out_ready randomly (50%) during a 4-tag drain -> all 64 qwords appear in order with no loss or duplication, and out_data is stable while stalled.
- Assert reset_n low mid-drain of tag 2 -> out_valid=0 and outstanding=0 immediately. After release, rr_tag=0.
- With HIFIFO_RC_PROTECT_EN defined, send a completion to tag 5 while only tags 0-1 are allocated -> error=1 and held; tag 0/1 output is unaffected.
